task3_feeder: RTL

Packet sequencer sitting directly upstream of `task3`; it produces that block's `data`/`start` input stream. A host pushes 33-bit words with an end-of-packet marker into an internal FIFO. Each complete packet is replayed as a back-to-back burst with `start` held high for every word, separated by a fixed low gap. This replaces hand-sequenced stimulus with a reusable, buffered source.

---
 rtl/task3_pkg.sv | 12 +
 rtl/task3_fifo.sv | 64 ++++++
 rtl/task3_feeder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/task3_pkg.sv
// Shared definitions for the task3 packet feeder: default word width and FSM state encoding.
package task3_pkg;

   localparam int WIDTH_DEF = 33;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/task3_fifo.sv
// Synchronous FIFO with push/pop, registered occupancy count and derived full/empty flags.
module task3_fifo
   import task3_pkg::*;
#(
   parameter  int WIDTH = WIDTH_DEF + 1,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
)
(
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // Overfilling or underflowing would corrupt the pointers, so guard locally as well.
   assign w_push = i_push && (r_count != CW'(DEPTH));
   assign w_pop  = i_pop  && (r_count != '0);

   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/task3_feeder.sv
// Buffers host-pushed words and replays each complete packet to task3 as a start-qualified burst.
//   state | meaning
//   IDLE  | waiting for a complete packet; launches one when pkt_cnt > 0
//   SEND  | popping one word per cycle until the last word of the packet
//   GAP   | start low for GAP cycles, then back to IDLE (which may launch at once)
module task3_feeder
   import task3_pkg::*;
#(
   parameter  int WIDTH = WIDTH_DEF,
   parameter  int DEPTH = 16,
   parameter  int GAP   = 1,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1
)
(
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_wr_en,
   input  logic             i_wr_last,
   output logic             o_full,
   output logic             o_overflow,
   output logic             o_trunc,
   output logic [WIDTH-1:0] o_data,
   output logic             o_start
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [GW-1:0]   r_gap_cnt;
   logic [GW-1:0]   w_gap_nxt;
   logic [CW-1:0]   r_pkt_cnt;
   logic [WIDTH-1:0] r_data;
   logic            r_start;
   logic            r_overflow;
   logic            r_trunc;

   logic            w_full;
   logic            w_empty;
   logic [CW-1:0]   w_count;
   logic [WIDTH:0]  w_head;
   logic            w_head_last;
   logic            w_accept;
   logic            w_force;
   logic            w_push_last;
   logic            w_pop;
   logic            w_pop_last;

   assign w_accept    = i_wr_en && !w_full;
   // A partial packet filling every entry could never be launched; close it off instead.
   assign w_force     = w_accept && !i_wr_last && (r_pkt_cnt == '0) && !w_pop &&
                        (w_count == CW'(DEPTH - 1));
   assign w_push_last = i_wr_last || w_force;
   assign w_head_last = w_head[WIDTH];
   assign w_pop_last  = w_pop && w_head_last;

   task3_fifo #(
      .WIDTH (WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_push  (w_accept),
      .i_pop   (w_pop),
      .i_data  ({w_push_last, i_wr_data}),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap_cnt;
      w_pop       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (r_pkt_cnt != '0) begin
               w_pop       = 1'b1;
               w_state_nxt = w_head_last ? ST_GAP : ST_SEND;
               w_gap_nxt   = GW'(GAP - 1);
            end
         end
         ST_SEND: begin
            w_pop = !w_empty;
            if (w_head_last) begin
               w_state_nxt = ST_GAP;
               w_gap_nxt   = GW'(GAP - 1);
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == '0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_gap_nxt = r_gap_cnt - GW'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_gap_cnt  <= '0;
         r_pkt_cnt  <= '0;
         r_data     <= '0;
         r_start    <= 1'b0;
         r_overflow <= 1'b0;
         r_trunc    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_gap_cnt  <= w_gap_nxt;
         r_start    <= w_pop;
         r_data     <= w_pop ? w_head[WIDTH-1:0] : '0;
         r_overflow <= i_wr_en && w_full;
         r_trunc    <= w_force;
         case ({w_accept && w_push_last, w_pop_last})
            2'b10:   r_pkt_cnt <= r_pkt_cnt + CW'(1);
            2'b01:   r_pkt_cnt <= r_pkt_cnt - CW'(1);
            default: r_pkt_cnt <= r_pkt_cnt;
         endcase
      end
   end

   assign o_full     = w_full;
   assign o_overflow = r_overflow;
   assign o_trunc    = r_trunc;
   assign o_data     = r_data;
   assign o_start    = r_start;

endmodule
